mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_arbiter_2.sv | 22 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e      : arbiter FSM state encoding (IDLE/ACCESS/RESP)
//   ADDR_W_DEF   : default memory address width
//   DATA_W_DEF   : default memory data width
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin choice, purely combinational.
//   req0, req1  : request lines of port 0 and port 1
//   last_grant  : index of the port granted most recently
//   grant       : index of the port to grant (meaningful only if a req is high)
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      // contention: the port that did not win last time goes first
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters (port 0 instruction fetch, port 1 load/store)
// onto a single synchronous RAM. One transaction at a time, fixed 3 cycles:
// IDLE (arbitrate + latch) -> ACCESS (RAM strobe) -> RESP (ack + read data).
//   clk, reset                       : clock, synchronous active-high reset
//   reqN/addrN/weN/wdataN (N=0,1)    : requester inputs, held until ackN
//   ackN, rdataN                     : one-cycle completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata : RAM command, driven in ACCESS only
//   mem_rdata                        : RAM read data, one cycle after mem_en
//   busy                             : high whenever the FSM is not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  // last_grant doubles as the latched index of the port in flight
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rhold0_q, rhold0_d;
  logic [DATA_W-1:0]   rhold1_q, rhold1_d;
  logic                grant;

  rr_arbiter_2 u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    // capture the RAM data seen during an ack so rdata holds afterwards
    rhold0_d     = ack0_q ? mem_rdata : rhold0_q;
    rhold1_d     = ack1_q ? mem_rdata : rhold1_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = ACCESS;
          last_grant_d = grant;
          addr_d       = grant ? addr1  : addr0;
          we_d         = grant ? we1    : we0;
          wdata_d      = grant ? wdata1 : wdata0;
          mem_en_d     = 1'b1;
          mem_we_d     = grant ? we1    : we0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack0_d  = ~last_grant_q;
        ack1_d  = last_grant_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      rhold0_q     <= '0;
      rhold1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      rhold0_q     <= rhold0_d;
      rhold1_q     <= rhold1_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  // RAM data arrives during RESP, so it is passed straight through while acked
  assign rdata0    = ack0_q ? mem_rdata : rhold0_q;
  assign rdata1    = ack1_q ? mem_rdata : rhold1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, mem_en, mem_we, busy;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] ram [0:255];
  logic       pre_en;
  logic [7:0] pre_addr, pre_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // synchronous RAM: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) chk("both_ack", {31'd0, ack0 & ack1}, 32'd0);
  end

  initial begin
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    pre_en = 0; pre_addr = 0; pre_data = 0;

    // reset state
    tick(); tick();
    chk("rst_busy",   busy,   0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ack0",   ack0,   0);
    chk("rst_ack1",   ack1,   0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    reset = 1'b0;

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy",   busy,   0);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_ack0",   ack0,   0);
      chk("idle_ack1",   ack1,   0);
    end

    // preload RAM[5]=2A
    pre_en = 1; pre_addr = 8'd5; pre_data = 8'h2A;
    tick();
    pre_en = 0;

    // port 1 read of address 5
    req1 = 1; addr1 = 8'd5; we1 = 0;
    tick();
    chk("r1_mem_en", mem_en,   1);
    chk("r1_addr",   mem_addr, 8'd5);
    chk("r1_we",     mem_we,   0);
    chk("r1_busy",   busy,     1);
    chk("r1_ack1_early", ack1, 0);
    tick();
    chk("r1_ack1",   ack1,   1);
    chk("r1_rdata1", rdata1, 8'h2A);
    chk("r1_ack0",   ack0,   0);
    chk("r1_mem_en_off", mem_en, 0);
    req1 = 0;
    tick();
    chk("r1_ack1_pulse", ack1,   0);
    chk("r1_idle_busy",  busy,   0);
    chk("r1_hold",       rdata1, 8'h2A);

    // port 0 write 3 <- 11, then port 1 reads it back
    req0 = 1; addr0 = 8'd3; we0 = 1; wdata0 = 8'h11;
    tick();
    chk("w0_mem_en", mem_en,    1);
    chk("w0_mem_we", mem_we,    1);
    chk("w0_addr",   mem_addr,  8'd3);
    chk("w0_wdata",  mem_wdata, 8'h11);
    tick();
    chk("w0_ack0", ack0, 1);
    chk("w0_ack1", ack1, 0);
    req0 = 0; we0 = 0;
    req1 = 1; addr1 = 8'd3; we1 = 0;
    tick();
    chk("w0_idle", busy, 0);
    chk("w0_ram",  ram[3], 8'h11);
    tick();
    chk("rb_addr", mem_addr, 8'd3);
    chk("rb_we",   mem_we,   0);
    tick();
    chk("rb_ack1",   ack1,   1);
    chk("rb_rdata1", rdata1, 8'h11);
    req1 = 0;
    tick();

    // contention after reset: grants alternate starting with port 0
    reset = 1'b1;
    tick(); tick();
    chk("rst2_rdata1", rdata1, 0);
    chk("rst2_busy",   busy,   0);
    reset = 1'b0;
    req0 = 1; addr0 = 8'd5; we0 = 0;
    req1 = 1; addr1 = 8'd3; we1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 8'd5 : 8'd3);
      tick();
      chk("rr_ack0", ack0, (k % 2 == 0) ? 1 : 0);
      chk("rr_ack1", ack1, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) chk("rr_rdata0", rdata0, 8'h2A);
      else            chk("rr_rdata1", rdata1, 8'h11);
      if (k == 3) begin req0 = 0; req1 = 0; end
      tick();
      chk("rr_idle", busy, 0);
    end

    // request dropped after grant still completes
    req1 = 1; addr1 = 8'd5; we1 = 0;
    tick();
    chk("drop_mem_en", mem_en, 1);
    req1 = 0;
    tick();
    chk("drop_ack1",   ack1,   1);
    chk("drop_rdata1", rdata1, 8'h2A);
    tick();

    // reset during ACCESS aborts the port 1 read
    req1 = 1; addr1 = 8'd5; we1 = 0;
    tick();
    chk("abort_mem_en", mem_en, 1);
    reset = 1'b1; req1 = 0;
    tick();
    chk("abort_ack1",   ack1,   0);
    chk("abort_busy",   busy,   0);
    chk("abort_mem_en_off", mem_en, 0);
    reset = 1'b0;
    tick();
    chk("abort_no_late_ack", ack1, 0);
    req0 = 1; addr0 = 8'd5; we0 = 0;
    tick();
    chk("post_mem_en", mem_en,   1);
    chk("post_addr",   mem_addr, 8'd5);
    tick();
    chk("post_ack0",   ack0,   1);
    chk("post_rdata0", rdata0, 8'h2A);
    chk("post_ack1",   ack1,   0);
    req0 = 0;
    tick();
    chk("post_hold0",  rdata0, 8'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
